csr_intr_ctrl: RTL and testbench

- Parametrised machine-mode interrupt controller for the 3-stage core.
- Synchronises and latches N interrupt sources, applies the mie/mstatus.MIE gating, and selects the highest-priority cause.
- Handshakes a trap request with the pipeline, then issues a registered redirect (trap vector or mret return) to the fetch stage.
- Feeds mip and mcause to the CSR file; the CSR file owns mstatus, mie, mtvec and mepc storage.

---
 rtl/csr_intr_pkg.sv | 33 +++
 rtl/csr_intr_ctrl_sync_pend.sv | 72 +++++++
 rtl/csr_intr_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_csr_intr_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_intr_pkg.sv
// Shared types, constants and the trap-target helper for the machine-mode
// interrupt controller.
package csr_intr_pkg;

   // Controller states: waiting for a cause, requesting a trap, handler running.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      HANDLER = 2'd2
   } intr_state_e;

   localparam int MSTATUS_MIE         = 3;
   localparam int IRQ_MTI             = 7;
   localparam int IRQ_MEI             = 11;
   localparam int MTVEC_MODE_VECTORED = 1;

   // Widest supported address; callers cast down to their own DW, which keeps
   // the result correct modulo 2^DW.
   localparam int TGT_W = 64;

   // Direct mode jumps to the aligned base; vectored mode adds 4*cause.
   function automatic logic [TGT_W-1:0] trap_target(input logic [TGT_W-1:0] mtvec,
                                                    input logic [TGT_W-1:0] cause);
      logic [TGT_W-1:0] base;
      base = {mtvec[TGT_W-1:2], 2'b00};
      if (mtvec[0] == 1'(MTVEC_MODE_VECTORED)) begin
         trap_target = base + (cause << 2);
      end else begin
         trap_target = base;
      end
   endfunction

endpackage

// File: rtl/csr_intr_ctrl_sync_pend.sv
// One interrupt source: synchroniser chain, rising-edge detect and the
// pending flop. Level sources follow the synchronised line; edge sources
// latch a 0->1 transition until the controller accepts them as the cause.
module intr_sync_pend #(
   parameter int SYNC_STAGES = 2,
   parameter bit IS_EDGE     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   input  logic clr,
   output logic pend
);

   logic irq_s;
   logic irq_d;
   logic rise;
   logic pend_nx;

   generate
      if (SYNC_STAGES > 0) begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;

         // Shift the raw line through the synchroniser chain.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= irq;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign irq_s = sync_q[SYNC_STAGES-1];
      end else begin : g_nosync
         assign irq_s = irq;
      end
   endgenerate

   // Remember the previous synchronised level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_d <= 1'b0;
      end else begin
         irq_d <= irq_s;
      end
   end

   assign rise = irq_s & ~irq_d;

   // Next pending value; a fresh edge beats a simultaneous accept-clear.
   always_comb begin
      pend_nx = 1'b0;
      if (IS_EDGE) begin
         pend_nx = rise | (pend & ~clr);
      end else begin
         pend_nx = irq_s;
      end
   end

   // Pending flop, also the mip bit seen by the CSR file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= 1'b0;
      end else begin
         pend <= pend_nx;
      end
   end

endmodule

// File: rtl/csr_intr_ctrl.sv
// Machine-mode interrupt controller: gathers pending sources, gates them with
// mie / mstatus.MIE, picks the highest-numbered cause, handshakes the trap
// with the pipeline and issues registered redirects for traps and mret.
module csr_intr_ctrl
   import csr_intr_pkg::*;
#(
   parameter int                 DW          = 32,
   parameter int                 NUM_IRQ     = 16,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK   = 16'h0000,
   parameter int                 SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [NUM_IRQ-1:0] mie_i,
   input  logic               mstatus_mie_i,
   input  logic [DW-1:0]      mtvec_i,
   input  logic [DW-1:0]      mepc_i,
   input  logic               is_mret_i,
   input  logic               trap_ack_i,
   output logic [NUM_IRQ-1:0] mip_o,
   output logic               intr_req_o,
   output logic               intr_flag_o,
   output logic [DW-1:0]      where_to_go_o,
   output logic [DW-1:0]      mcause_o,
   output logic               mcause_we_o,
   output logic               in_handler_o
);

   localparam int SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] clr;
   logic [NUM_IRQ-1:0] elig;
   logic               go;
   logic               accept;
   logic [SEL_W-1:0]   sel;
   logic [SEL_W-1:0]   cause_q;
   logic [SEL_W-1:0]   cause_nx;
   logic [DW-1:0]      trap_tgt;
   intr_state_e        state_q;
   intr_state_e        state_nx;

   logic               req_nx;
   logic               flag_nx;
   logic               we_nx;
   logic               handler_nx;
   logic [DW-1:0]      where_nx;
   logic [DW-1:0]      mcause_nx;

   // Per-source synchroniser and pending latch.
   generate
      for (genvar k = 0; k < NUM_IRQ; k++) begin : g_src
         intr_sync_pend #(
            .SYNC_STAGES (SYNC_STAGES),
            .IS_EDGE     (EDGE_MASK[k])
         ) u_src (
            .clk  (clk),
            .rst  (rst),
            .irq  (irq_i[k]),
            .clr  (clr[k]),
            .pend (pend[k])
         );
      end
   endgenerate

   assign mip_o  = pend;
   assign elig   = pend & mie_i;
   assign go     = (|elig) & mstatus_mie_i;
   assign accept = (state_q == REQ) && trap_ack_i;

   // Priority encoder: the highest eligible index wins (later writes override).
   always_comb begin
      sel = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         sel = elig[k] ? SEL_W'(k) : sel;
      end
   end

   // Clear an edge-latched source only when it is the cause being accepted.
   always_comb begin
      clr = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         if (accept && (cause_q == SEL_W'(k))) begin
            clr[k] = 1'b1;
         end else begin
            clr[k] = 1'b0;
         end
      end
   end

   // Trap target for the currently latched cause, reduced to DW bits.
   always_comb begin
      trap_tgt = DW'(trap_target(TGT_W'(mtvec_i), TGT_W'(cause_q)));
   end

   // Next-state and next-output logic; a trap accept masks a same-cycle mret.
   always_comb begin
      state_nx   = state_q;
      cause_nx   = cause_q;
      req_nx     = 1'b0;
      flag_nx    = 1'b0;
      we_nx      = 1'b0;
      handler_nx = 1'b0;
      where_nx   = where_to_go_o;
      mcause_nx  = mcause_o;
      case (state_q)
         IDLE: begin
            if (go) begin
               state_nx = REQ;
               cause_nx = sel;
               req_nx   = 1'b1;
            end else begin
               state_nx = IDLE;
            end
            if (is_mret_i) begin
               flag_nx  = 1'b1;
               where_nx = mepc_i;
            end else begin
               flag_nx  = 1'b0;
            end
         end
         REQ: begin
            if (trap_ack_i) begin
               state_nx   = HANDLER;
               flag_nx    = 1'b1;
               we_nx      = 1'b1;
               handler_nx = 1'b1;
               where_nx   = trap_tgt;
               mcause_nx  = DW'(cause_q);
               mcause_nx[DW-1] = 1'b1;
            end else begin
               if (go) begin
                  cause_nx = sel;
                  req_nx   = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
               if (is_mret_i) begin
                  flag_nx  = 1'b1;
                  where_nx = mepc_i;
               end else begin
                  flag_nx  = 1'b0;
               end
            end
         end
         HANDLER: begin
            if (is_mret_i) begin
               state_nx   = IDLE;
               flag_nx    = 1'b1;
               where_nx   = mepc_i;
               handler_nx = 1'b0;
            end else begin
               handler_nx = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and latched cause registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cause_q <= '0;
      end else begin
         state_q <= state_nx;
         cause_q <= cause_nx;
      end
   end

   // Registered outputs towards the pipeline and CSR file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         intr_req_o    <= 1'b0;
         intr_flag_o   <= 1'b0;
         mcause_we_o   <= 1'b0;
         in_handler_o  <= 1'b0;
         where_to_go_o <= '0;
         mcause_o      <= '0;
      end else begin
         intr_req_o    <= req_nx;
         intr_flag_o   <= flag_nx;
         mcause_we_o   <= we_nx;
         in_handler_o  <= handler_nx;
         where_to_go_o <= where_nx;
         mcause_o      <= mcause_nx;
      end
   end

endmodule

// File: tb/tb_csr_intr_ctrl.sv
// Self-checking bench for csr_intr_ctrl: directed scenarios plus a random
// run, all compared against a behavioural model of the controller rules.
module tb_csr_intr_ctrl;

   localparam int          DW   = 32;
   localparam int          NIRQ = 16;
   localparam int          SYNC = 2;
   localparam logic [15:0] EDGE = 16'h0028;

   logic            clk = 1'b0;
   logic            rst;
   logic [NIRQ-1:0] irq, mie, mip;
   logic            mstatus_mie, is_mret, trap_ack;
   logic [DW-1:0]   mtvec, mepc, where_to_go, mcause;
   logic            intr_req, intr_flag, mcause_we, in_handler;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state (values expected after the next edge)
   logic [15:0] m_pend, m_prev;
   logic        m_wait, m_hand, m_flag, m_we;
   int          m_cause;
   logic [31:0] m_where, m_mcause;
   logic [15:0] hist[$];

   csr_intr_ctrl #(.DW(DW), .NUM_IRQ(NIRQ), .EDGE_MASK(EDGE), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .irq_i(irq), .mie_i(mie), .mstatus_mie_i(mstatus_mie),
      .mtvec_i(mtvec), .mepc_i(mepc), .is_mret_i(is_mret), .trap_ack_i(trap_ack),
      .mip_o(mip), .intr_req_o(intr_req), .intr_flag_o(intr_flag),
      .where_to_go_o(where_to_go), .mcause_o(mcause), .mcause_we_o(mcause_we),
      .in_handler_o(in_handler));

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pend = '0; m_prev = '0; m_wait = 1'b0; m_hand = 1'b0; m_flag = 1'b0;
      m_we = 1'b0; m_cause = 0; m_where = '0; m_mcause = '0;
      hist.delete();
   endtask

   // Advance one clock: evaluate the controller rules on the current inputs,
   // then wait for the edge and settle 1 time unit after it.
   task automatic step();
      logic [15:0] irq_s, elig, rise, pend_n;
      logic        go, accept, hb, wb;
      int          sel;
      irq_s  = (hist.size() >= SYNC) ? hist[SYNC-1] : 16'h0000;
      elig   = m_pend & mie;
      go     = (elig != 16'h0000) && mstatus_mie;
      sel    = 0;
      for (int k = 15; k >= 0; k--) begin
         if (elig[k]) begin sel = k; break; end
      end
      accept = m_wait && trap_ack;
      rise   = irq_s & ~m_prev;
      for (int k = 0; k < 16; k++) begin
         if (EDGE[k]) pend_n[k] = rise[k] | (m_pend[k] & !(accept && m_cause == k));
         else         pend_n[k] = irq_s[k];
      end
      hb = m_hand; wb = m_wait;
      m_flag = 1'b0; m_we = 1'b0;
      if (accept) begin
         m_wait = 1'b0; m_hand = 1'b1; m_flag = 1'b1; m_we = 1'b1;
         m_mcause = 32'h8000_0000 | 32'(m_cause);
         if (mtvec[0]) m_where = (mtvec & 32'hFFFF_FFFC) + 32'(m_cause * 4);
         else          m_where = mtvec & 32'hFFFF_FFFC;
      end else begin
         if (is_mret) begin m_flag = 1'b1; m_where = mepc; end
         if (hb) begin
            if (is_mret) m_hand = 1'b0;
         end else if (wb) begin
            if (go) m_cause = sel; else m_wait = 1'b0;
         end else if (go) begin
            m_wait = 1'b1; m_cause = sel;
         end
      end
      m_prev = irq_s;
      m_pend = pend_n;
      hist.push_front(irq);
      if (hist.size() > SYNC) void'(hist.pop_back());
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int bound, output int n);
      n = 0;
      while (intr_req !== 1'b1 && n < bound) begin step(); n++; end
   endtask

   task automatic clear_inputs();
      irq = '0; mie = '0; mstatus_mie = 1'b0; mtvec = '0; mepc = '0;
      is_mret = 1'b0; trap_ack = 1'b0;
   endtask

   // Bring the controller back to idle with no sources active.
   task automatic return_idle();
      irq = '0; trap_ack = 1'b0; is_mret = 1'b0;
      repeat (SYNC + 2) step();
      for (int i = 0; i < 10; i++) begin
         trap_ack = intr_req;
         is_mret  = in_handler && !intr_req;
         step();
      end
      trap_ack = 1'b0; is_mret = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (intr_req !== 1'b0 || intr_flag !== 1'b0 || mcause_we !== 1'b0 || in_handler !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl got=%b%b%b%b exp=0000", intr_req, intr_flag, mcause_we, in_handler); end
      n_tests++; if (mip !== 16'h0000 || where_to_go !== 32'h0 || mcause !== 32'h0) begin n_fail++; $display("FAIL reset_data mip=%h where=%h mcause=%h exp=0", mip, where_to_go, mcause); end
      rst = 1'b0;
      step();
      n_tests++; if (intr_req !== 1'b0 || in_handler !== 1'b0 || mip !== 16'h0000) begin n_fail++; $display("FAIL reset_release req=%b hnd=%b mip=%h exp=0", intr_req, in_handler, mip); end
   endtask

   task automatic test_level_timer();
      int n;
      mtvec = 32'h100; mie = 16'h0080; mstatus_mie = 1'b1; irq = 16'h0080;
      wait_req(20, n);
      n_tests++; if (n !== 4) begin n_fail++; $display("FAIL timer_latency got=%0d exp=4", n); end
      trap_ack = 1'b1; step(); trap_ack = 1'b0;
      n_tests++; if (intr_flag !== 1'b1 || mcause_we !== 1'b1) begin n_fail++; $display("FAIL timer_pulse flag=%b we=%b exp=11", intr_flag, mcause_we); end
      n_tests++; if (where_to_go !== 32'h100) begin n_fail++; $display("FAIL timer_target got=%h exp=00000100", where_to_go); end
      n_tests++; if (mcause !== 32'h8000_0007) begin n_fail++; $display("FAIL timer_mcause got=%h exp=80000007", mcause); end
      n_tests++; if (in_handler !== 1'b1 || intr_req !== 1'b0) begin n_fail++; $display("FAIL timer_handler hnd=%b req=%b exp=10", in_handler, intr_req); end
      repeat (5) step();
      n_tests++; if (intr_flag !== 1'b0 || mcause_we !== 1'b0 || intr_req !== 1'b0 || in_handler !== 1'b1) begin n_fail++; $display("FAIL timer_hold flag=%b we=%b req=%b hnd=%b exp=0001", intr_flag, mcause_we, intr_req, in_handler); end
      n_tests++; if (where_to_go !== 32'h100) begin n_fail++; $display("FAIL timer_where_hold got=%h exp=00000100", where_to_go); end
      irq = '0; repeat (4) step();
      mepc = 32'h400; is_mret = 1'b1; step(); is_mret = 1'b0;
      n_tests++; if (intr_flag !== 1'b1 || where_to_go !== 32'h400 || in_handler !== 1'b0) begin n_fail++; $display("FAIL timer_mret flag=%b where=%h hnd=%b exp=1/00000400/0", intr_flag, where_to_go, in_handler); end
      return_idle();
   endtask

   task automatic test_vectored_priority();
      int n;
      mtvec = 32'h201; mie = 16'h0880; mstatus_mie = 1'b1; irq = 16'h0880;
      wait_req(20, n);
      trap_ack = 1'b1; step(); trap_ack = 1'b0;
      n_tests++; if (mcause !== 32'h8000_000B) begin n_fail++; $display("FAIL prio_mcause got=%h exp=8000000b", mcause); end
      n_tests++; if (where_to_go !== 32'h22C) begin n_fail++; $display("FAIL prio_target got=%h exp=0000022c", where_to_go); end
      return_idle();
   endtask

   task automatic test_edge();
      int n;
      mtvec = 32'h100; mie = 16'h0000; mstatus_mie = 1'b1;
      irq = 16'h0008; step(); irq = '0;
      repeat (4) step();
      n_tests++; if (mip[3] !== 1'b1 || intr_req !== 1'b0) begin n_fail++; $display("FAIL edge_latched mip3=%b req=%b exp=10", mip[3], intr_req); end
      repeat (3) step();
      n_tests++; if (mip[3] !== 1'b1 || intr_req !== 1'b0) begin n_fail++; $display("FAIL edge_held mip3=%b req=%b exp=10", mip[3], intr_req); end
      mie = 16'h0008;
      wait_req(10, n);
      n_tests++; if (n !== 1) begin n_fail++; $display("FAIL edge_req_latency got=%0d exp=1", n); end
      trap_ack = 1'b1; step(); trap_ack = 1'b0;
      n_tests++; if (mcause !== 32'h8000_0003 || intr_flag !== 1'b1) begin n_fail++; $display("FAIL edge_trap mcause=%h flag=%b exp=80000003/1", mcause, intr_flag); end
      n_tests++; if (mip[3] !== 1'b0) begin n_fail++; $display("FAIL edge_clear got=%b exp=0", mip[3]); end
      return_idle();
   endtask

   task automatic test_abort_mret();
      int n;
      mtvec = 32'h100; mie = 16'h0080; mstatus_mie = 1'b1; irq = 16'h0080;
      wait_req(20, n);
      mstatus_mie = 1'b0; step();
      n_tests++; if (intr_req !== 1'b0 || in_handler !== 1'b0 || intr_flag !== 1'b0) begin n_fail++; $display("FAIL abort_drop req=%b hnd=%b flag=%b exp=000", intr_req, in_handler, intr_flag); end
      step();
      mstatus_mie = 1'b1; step();
      n_tests++; if (intr_req !== 1'b1) begin n_fail++; $display("FAIL abort_rearm got=%b exp=1", intr_req); end
      trap_ack = 1'b1; step(); trap_ack = 1'b0;
      irq = '0; repeat (4) step();
      mepc = 32'h80; is_mret = 1'b1; step(); is_mret = 1'b0;
      n_tests++; if (intr_flag !== 1'b1 || where_to_go !== 32'h80 || in_handler !== 1'b0) begin n_fail++; $display("FAIL abort_mret flag=%b where=%h hnd=%b exp=1/00000080/0", intr_flag, where_to_go, in_handler); end
      step();
      n_tests++; if (intr_flag !== 1'b0 || intr_req !== 1'b0) begin n_fail++; $display("FAIL abort_idle flag=%b req=%b exp=00", intr_flag, intr_req); end
      return_idle();
   endtask

   task automatic test_collision_reset();
      int n;
      mtvec = 32'h100; mie = 16'h0080; mstatus_mie = 1'b1; irq = 16'h0080;
      wait_req(20, n);
      mepc = 32'h1234; trap_ack = 1'b1; is_mret = 1'b1; step();
      trap_ack = 1'b0; is_mret = 1'b0;
      n_tests++; if (intr_flag !== 1'b1 || where_to_go !== 32'h100 || in_handler !== 1'b1) begin n_fail++; $display("FAIL collide_trap flag=%b where=%h hnd=%b exp=1/00000100/1", intr_flag, where_to_go, in_handler); end
      step();
      n_tests++; if (intr_flag !== 1'b0 || where_to_go !== 32'h100) begin n_fail++; $display("FAIL collide_single flag=%b where=%h exp=0/00000100", intr_flag, where_to_go); end
      // asynchronous reset while in the handler
      rst = 1'b1; #1;
      n_tests++; if (intr_req !== 1'b0 || intr_flag !== 1'b0 || mcause_we !== 1'b0 || in_handler !== 1'b0 || mip !== 16'h0 || where_to_go !== 32'h0 || mcause !== 32'h0) begin n_fail++; $display("FAIL async_reset hnd=%b mip=%h where=%h mcause=%h exp=all0", in_handler, mip, where_to_go, mcause); end
      clear_inputs();
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      step();
      n_tests++; if (in_handler !== 1'b0 || intr_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle hnd=%b req=%b exp=00", in_handler, intr_req); end
   endtask

   task automatic test_random();
      mtvec = $urandom; mie = 16'($urandom); mstatus_mie = 1'b1; irq = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) irq = irq ^ 16'(32'd1 << $urandom_range(0, 15));
         if ($urandom_range(0, 31) == 0) mie = 16'($urandom);
         mstatus_mie = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 63) == 0) mtvec = $urandom;
         mepc     = $urandom;
         trap_ack = intr_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         is_mret  = in_handler ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
         step();
         n_tests++; if (mip !== m_pend) begin n_fail++; $display("FAIL rand_mip cyc=%0d got=%h exp=%h", c, mip, m_pend); end
         n_tests++; if (intr_req !== m_wait) begin n_fail++; $display("FAIL rand_req cyc=%0d got=%b exp=%b", c, intr_req, m_wait); end
         n_tests++; if (in_handler !== m_hand) begin n_fail++; $display("FAIL rand_handler cyc=%0d got=%b exp=%b", c, in_handler, m_hand); end
         n_tests++; if (intr_flag !== m_flag) begin n_fail++; $display("FAIL rand_flag cyc=%0d got=%b exp=%b", c, intr_flag, m_flag); end
         n_tests++; if (mcause_we !== m_we) begin n_fail++; $display("FAIL rand_we cyc=%0d got=%b exp=%b", c, mcause_we, m_we); end
         n_tests++; if (where_to_go !== m_where) begin n_fail++; $display("FAIL rand_where cyc=%0d got=%h exp=%h", c, where_to_go, m_where); end
         n_tests++; if (mcause !== m_mcause) begin n_fail++; $display("FAIL rand_mcause cyc=%0d got=%h exp=%h", c, mcause, m_mcause); end
      end
      return_idle();
   endtask

   initial begin
      test_reset();
      test_level_timer();
      test_vectored_priority();
      test_edge();
      test_abort_mret();
      test_collision_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
